traffic_phase_ctrl: RTL and testbench

Parametrised multi-approach traffic-light phase controller. Successor to the two-state red/green controller. Cycles NUM_DIR approaches through GREEN -> YELLOW -> ALL_RED, one approach at a time. Each approach's green time is picked from three programmable durations using its own 2-bit flow level from the video-analysis path. Driven by the 1 s tick generator; its outputs feed the VGA overlay and the status logic.

---
 rtl/traffic_phase_ctrl_if.sv | 31 +++
 rtl/traffic_phase_ctrl.sv | 124 ++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_phase_ctrl_if.sv
// Bus between the phase controller and its environment: tick, flow levels,
// programmable green durations and hold in; lights and phase status out.
interface traffic_phase_ctrl_if #(
    parameter int NUM_DIR = 2,
    parameter int CNT_W   = 5
);
    localparam int DIR_W = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1;

    logic                   tick_sec;
    logic [2*NUM_DIR-1:0]   traffic_sel;
    logic [CNT_W-1:0]       green_lo;
    logic [CNT_W-1:0]       green_mid;
    logic [CNT_W-1:0]       green_hi;
    logic                   hold;

    logic [2*NUM_DIR-1:0]   o_light;
    logic [DIR_W-1:0]       o_active_dir;
    logic [1:0]             o_level;
    logic [CNT_W-1:0]       o_remain;
    logic                   o_phase_valid;

    modport master (
        output tick_sec, traffic_sel, green_lo, green_mid, green_hi, hold,
        input  o_light, o_active_dir, o_level, o_remain, o_phase_valid
    );

    modport slave (
        input  tick_sec, traffic_sel, green_lo, green_mid, green_hi, hold,
        output o_light, o_active_dir, o_level, o_remain, o_phase_valid
    );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Multi-approach traffic-light phase controller. Serves one approach at a
// time through GREEN -> YELLOW -> ALL_RED; green time is chosen per approach
// from its flow level at the moment the phase is loaded.
module traffic_phase_ctrl #(
    parameter int NUM_DIR    = 2,
    parameter int CNT_W      = 5,
    parameter int YELLOW_SEC = 3,
    parameter int ALLRED_SEC = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    traffic_phase_ctrl_if.slave  bus
);
    localparam int DIR_W = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1;
    localparam logic [CNT_W-1:0] YEL_CNT  = CNT_W'(YELLOW_SEC);
    localparam logic [CNT_W-1:0] RED_CNT  = CNT_W'(ALLRED_SEC);
    localparam logic [DIR_W-1:0] LAST_DIR = DIR_W'(NUM_DIR - 1);

    typedef enum logic [2:0] {
        S_INIT, S_LOAD, S_GREEN, S_YELLOW, S_ALL_RED
    } state_t;

    state_t               r_state;
    logic [DIR_W-1:0]     r_dir;
    logic [1:0]           r_level;
    logic [CNT_W-1:0]     r_remain;
    logic [2*NUM_DIR-1:0] r_light;
    logic                 r_pv;

    logic [1:0]           w_lvl;
    logic [CNT_W-1:0]     w_green;
    logic [DIR_W-1:0]     w_next_dir;
    logic                 w_last_tick;

    // Level of the approach about to be served and its (clamped) green time.
    always_comb begin
        w_lvl = bus.traffic_sel[{r_dir, 1'b0} +: 2];
        case (w_lvl)
            2'b00:   w_green = bus.green_lo;
            2'b01:   w_green = bus.green_mid;
            default: w_green = bus.green_hi;
        endcase
        if (w_green == '0)
            w_green = CNT_W'(1);
        w_next_dir  = (r_dir == LAST_DIR) ? '0 : r_dir + DIR_W'(1);
        w_last_tick = (r_remain == CNT_W'(1));
    end

    // Phase sequencer; every output is a register so the overlay sees clean values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_INIT;
            r_dir    <= '0;
            r_level  <= '0;
            r_remain <= '0;
            r_light  <= '0;
            r_pv     <= 1'b0;
        end else begin
            r_pv <= 1'b0;
            case (r_state)
                S_INIT: begin
                    r_state <= S_LOAD;
                    r_dir   <= '0;
                end
                S_LOAD: begin
                    // Ticks here are dropped; the full green is loaded instead.
                    r_level  <= w_lvl;
                    r_remain <= w_green;
                    r_light  <= '0;
                    r_light[{r_dir, 1'b0} +: 2] <= 2'b01;
                    r_pv     <= 1'b1;
                    r_state  <= S_GREEN;
                end
                S_GREEN: begin
                    if (bus.tick_sec && !bus.hold) begin
                        if (w_last_tick) begin
                            r_state  <= S_YELLOW;
                            r_remain <= YEL_CNT;
                            r_light[{r_dir, 1'b0} +: 2] <= 2'b10;
                        end else begin
                            r_remain <= r_remain - CNT_W'(1);
                        end
                    end
                end
                S_YELLOW: begin
                    if (bus.tick_sec) begin
                        if (w_last_tick) begin
                            r_light <= '0;
                            if (ALLRED_SEC > 0) begin
                                r_state  <= S_ALL_RED;
                                r_remain <= RED_CNT;
                            end else begin
                                r_state  <= S_LOAD;
                                r_remain <= '0;
                                r_dir    <= w_next_dir;
                            end
                        end else begin
                            r_remain <= r_remain - CNT_W'(1);
                        end
                    end
                end
                S_ALL_RED: begin
                    if (bus.tick_sec) begin
                        if (w_last_tick) begin
                            r_state <= S_LOAD;
                            r_dir   <= w_next_dir;
                        end
                        r_remain <= r_remain - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_INIT;
                    r_light <= '0;
                end
            endcase
        end
    end

    assign bus.o_light       = r_light;
    assign bus.o_active_dir  = r_dir;
    assign bus.o_level       = r_level;
    assign bus.o_remain      = r_remain;
    assign bus.o_phase_valid = r_pv;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: a 2-approach instance with all-red clearance
// and a 4-approach instance without it, both fed the same tick/hold/greens.
// Phases are measured in ticks and compared against durations derived from
// the level -> green rules.
module tb_traffic_phase_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       tick, hold;
    logic [3:0] sel_a;
    logic [7:0] sel_b;
    logic [4:0] glo, gmid, ghi;

    int n_tests = 0;
    int n_fail  = 0;

    traffic_phase_ctrl_if #(.NUM_DIR(2), .CNT_W(5)) ifa ();
    traffic_phase_ctrl_if #(.NUM_DIR(4), .CNT_W(5)) ifb ();

    assign ifa.tick_sec = tick;   assign ifb.tick_sec = tick;
    assign ifa.hold = hold;       assign ifb.hold = hold;
    assign ifa.traffic_sel = sel_a;
    assign ifb.traffic_sel = sel_b;
    assign ifa.green_lo = glo;    assign ifb.green_lo = glo;
    assign ifa.green_mid = gmid;  assign ifb.green_mid = gmid;
    assign ifa.green_hi = ghi;    assign ifb.green_hi = ghi;

    traffic_phase_ctrl #(.NUM_DIR(2), .CNT_W(5), .YELLOW_SEC(3), .ALLRED_SEC(1))
        dut_a (.clk(clk), .reset(reset), .bus(ifa));
    traffic_phase_ctrl #(.NUM_DIR(4), .CNT_W(5), .YELLOW_SEC(3), .ALLRED_SEC(0))
        dut_b (.clk(clk), .reset(reset), .bus(ifb));

    // Green seconds for a level, straight from the selection table with clamp.
    function automatic int exp_green(input logic [1:0] l, input logic [4:0] lo, mid, hi);
        int g;
        case (l)
            2'b00:   g = int'(lo);
            2'b01:   g = int'(mid);
            default: g = int'(hi);
        endcase
        if (g == 0) g = 1;
        return g;
    endfunction

    function automatic logic [1:0] sel_of(input int which, input int d);
        logic [1:0] v;
        if (which == 0) v = sel_a[2*d +: 2];
        else            v = sel_b[2*d +: 2];
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int which, output logic [7:0] lt, output int dir,
                          output int lvl, output int rem, output logic pv);
        if (which == 0) begin
            lt = {4'b0, ifa.o_light}; dir = int'(ifa.o_active_dir);
            lvl = int'(ifa.o_level);  rem = int'(ifa.o_remain); pv = ifa.o_phase_valid;
        end else begin
            lt = ifb.o_light;         dir = int'(ifb.o_active_dir);
            lvl = int'(ifb.o_level);  rem = int'(ifb.o_remain); pv = ifb.o_phase_valid;
        end
    endtask

    task automatic do_reset();
        tick = 1'b0; hold = 1'b0; reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
    endtask

    // Drives ticks (one every 'period' clocks) through one whole phase and
    // reports what it observed: entry values, ticks spent in each colour,
    // phase_valid pulses and safety flags. Ends when the next LOAD is seen.
    task automatic measure(input int which, input int period, input int hold_at,
                           input int hold_n, input bit hold_yel, input bit scramble,
                           output int dir, output int lvl, output int rem0,
                           output int g, output int gt, output int y, output int r,
                           output int pvs, output bit light_ok, output bit multi,
                           output bit hold_bad, output bit timeout);
        int n, tc, stage, cnt, left, d, l, rm, nonred;
        bit holding, tk, hd;
        logic [7:0] lt;
        logic pv;
        n = (which == 0) ? 2 : 4;
        tc = 0; stage = -1; cnt = 0; left = hold_n; holding = 1'b0;
        dir = 0; lvl = 0; rem0 = 0; g = 0; gt = 0; y = 0; r = 0; pvs = 0;
        light_ok = 1'b0; multi = 1'b0; hold_bad = 1'b0; timeout = 1'b0;
        while (1) begin
            sample(which, lt, d, l, rm, pv);
            cnt++;
            if (cnt > 5000) begin timeout = 1'b1; break; end
            nonred = 0;
            for (int k = 0; k < n; k++) if (lt[2*k +: 2] != 2'b00) nonred++;
            if (nonred > 1) multi = 1'b1;
            if (stage < 0 && pv) begin
                stage = 0; dir = d; lvl = l; rem0 = rm;
                light_ok = (lt[2*d +: 2] == 2'b01);
                if (scramble) begin
                    sel_a = 4'($urandom); sel_b = 8'($urandom);
                    glo = 5'($urandom); gmid = 5'($urandom); ghi = 5'($urandom);
                end
            end
            if (pv) pvs++;
            if (stage >= 1 && nonred == 0 && rm == 0) break;
            if (stage == 0 && lt[2*dir +: 2] == 2'b10) stage = 1;
            if (stage == 1 && nonred == 0) stage = 2;
            tk = ((tc % period) == period - 1);
            tc++;
            hd = 1'b0;
            if (stage == 0 && left > 0 && (holding || rm == hold_at)) begin
                hd = 1'b1; holding = 1'b1;
                if (rm != hold_at) hold_bad = 1'b1;
            end
            if (stage == 1 && hold_yel) hd = 1'b1;
            tick = tk; hold = hd;
            if (tk) begin
                case (stage)
                    0: begin gt++; if (!hd) g++; else left--; end
                    1: y++;
                    2: r++;
                    default: ;
                endcase
            end
            cyc();
        end
        tick = 1'b0; hold = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick = 1'b0; hold = 1'b0;
        sel_a = 4'b0000; sel_b = 8'h00; glo = 5'd4; gmid = 5'd6; ghi = 5'd9;
        cyc();
        n_tests++;
        if (ifa.o_light !== 4'b0 || ifb.o_light !== 8'b0) begin
            n_fail++; $display("FAIL reset_light: got %b/%b want all 00", ifa.o_light, ifb.o_light);
        end
        n_tests++;
        if (ifa.o_active_dir !== 1'b0 || ifa.o_level !== 2'b0 || ifa.o_remain !== 5'd0 || ifa.o_phase_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_state_a: got dir %0d lvl %0d rem %0d pv %0b want 0 0 0 0",
                               ifa.o_active_dir, ifa.o_level, ifa.o_remain, ifa.o_phase_valid);
        end
        n_tests++;
        if (ifb.o_active_dir !== 2'b0 || ifb.o_remain !== 5'd0 || ifb.o_phase_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_state_b: got dir %0d rem %0d pv %0b want 0 0 0",
                               ifb.o_active_dir, ifb.o_remain, ifb.o_phase_valid);
        end
        reset = 1'b0;
        cyc();  // INIT -> LOAD
        n_tests++;
        if (ifa.o_light !== 4'b0 || ifa.o_phase_valid !== 1'b0) begin
            n_fail++; $display("FAIL load_red: got light %b pv %0b want 0000 0", ifa.o_light, ifa.o_phase_valid);
        end
        cyc();  // LOAD -> GREEN
        n_tests++;
        if (ifa.o_light !== 4'b0001 || ifa.o_phase_valid !== 1'b1 || ifa.o_remain !== 5'd4) begin
            n_fail++; $display("FAIL green_entry: got light %b pv %0b rem %0d want 0001 1 4",
                               ifa.o_light, ifa.o_phase_valid, ifa.o_remain);
        end
        cyc();
        n_tests++;
        if (ifa.o_phase_valid !== 1'b0) begin
            n_fail++; $display("FAIL pv_single: got %0b want 0", ifa.o_phase_valid);
        end
    endtask

    task automatic test_basic_cycle();
        int dir, lvl, rem0, g, gt, y, r, pvs;
        bit lok, multi, hb, to;
        int exp_dir[3] = '{0, 1, 0};
        int exp_lvl[3] = '{0, 1, 0};
        int exp_g[3]   = '{4, 6, 4};
        sel_a = 4'b0100; glo = 5'd4; gmid = 5'd6; ghi = 5'd9;
        do_reset();
        for (int p = 0; p < 3; p++) begin
            measure(0, 10, 0, 0, 1'b0, 1'b0, dir, lvl, rem0, g, gt, y, r, pvs, lok, multi, hb, to);
            n_tests++;
            if (to || dir != exp_dir[p] || lvl != exp_lvl[p]) begin
                n_fail++; $display("FAIL basic_dir_lvl ph%0d: got dir %0d lvl %0d to %0b want %0d %0d 0",
                                   p, dir, lvl, to, exp_dir[p], exp_lvl[p]);
            end
            n_tests++;
            if (g != exp_g[p] || rem0 != exp_g[p] || y != 3 || r != 1) begin
                n_fail++; $display("FAIL basic_durations ph%0d: got g %0d rem0 %0d y %0d r %0d want %0d %0d 3 1",
                                   p, g, rem0, y, r, exp_g[p], exp_g[p]);
            end
            n_tests++;
            if (pvs != 1 || !lok || multi) begin
                n_fail++; $display("FAIL basic_pv ph%0d: got pvs %0d light_ok %0b multi %0b want 1 1 0", p, pvs, lok, multi);
            end
        end
    endtask

    task automatic test_levels();
        int dir, lvl, rem0, g, gt, y, r, pvs;
        bit lok, multi, hb, to;
        sel_a = 4'b0011; glo = 5'd4; gmid = 5'd6; ghi = 5'd9;
        do_reset();
        measure(0, 3, 0, 0, 1'b0, 1'b0, dir, lvl, rem0, g, gt, y, r, pvs, lok, multi, hb, to);
        n_tests++;
        if (to || lvl != 3 || g != 9 || rem0 != 9) begin
            n_fail++; $display("FAIL level_hi: got lvl %0d g %0d rem0 %0d want 3 9 9", lvl, g, rem0);
        end
        sel_a = 4'b0000; glo = 5'd0;
        do_reset();
        measure(0, 3, 0, 0, 1'b0, 1'b0, dir, lvl, rem0, g, gt, y, r, pvs, lok, multi, hb, to);
        n_tests++;
        if (to || lvl != 0 || g != 1 || rem0 != 1) begin
            n_fail++; $display("FAIL green_clamp: got lvl %0d g %0d rem0 %0d want 0 1 1", lvl, g, rem0);
        end
    endtask

    task automatic test_hold();
        int dir, lvl, rem0, g, gt, y, r, pvs;
        bit lok, multi, hb, to;
        sel_a = 4'b0000; glo = 5'd4;
        do_reset();
        measure(0, 10, 2, 5, 1'b1, 1'b0, dir, lvl, rem0, g, gt, y, r, pvs, lok, multi, hb, to);
        n_tests++;
        if (to || hb) begin
            n_fail++; $display("FAIL hold_freeze: got hold_bad %0b to %0b want 0 0", hb, to);
        end
        n_tests++;
        if (g != 4 || gt != 9) begin
            n_fail++; $display("FAIL hold_extend: got counted %0d total %0d want 4 9", g, gt);
        end
        n_tests++;
        if (y != 3 || r != 1) begin
            n_fail++; $display("FAIL hold_yellow: got y %0d r %0d want 3 1", y, r);
        end
    endtask

    task automatic test_load_tick();
        int dir, lvl, rem0, g, gt, y, r, pvs;
        bit lok, multi, hb, to;
        int eg;
        sel_a = 4'b0100; glo = 5'd4; gmid = 5'd6;
        do_reset();
        for (int p = 0; p < 3; p++) begin
            eg = exp_green(sel_of(0, p % 2), glo, gmid, ghi);
            measure(0, 1, 0, 0, 1'b0, 1'b0, dir, lvl, rem0, g, gt, y, r, pvs, lok, multi, hb, to);
            n_tests++;
            if (to || rem0 != eg || g != eg || dir != p % 2) begin
                n_fail++; $display("FAIL load_tick ph%0d: got dir %0d rem0 %0d g %0d want %0d %0d %0d",
                                   p, dir, rem0, g, p % 2, eg, eg);
            end
        end
    endtask

    task automatic test_no_allred();
        int dir, lvl, rem0, g, gt, y, r, pvs;
        bit lok, multi, hb, to;
        int eg;
        sel_b = 8'b11_10_01_00; glo = 5'd2; gmid = 5'd3; ghi = 5'd4;
        do_reset();
        for (int p = 0; p < 5; p++) begin
            eg = exp_green(sel_of(1, p % 4), glo, gmid, ghi);
            measure(1, 2, 0, 0, 1'b0, 1'b0, dir, lvl, rem0, g, gt, y, r, pvs, lok, multi, hb, to);
            n_tests++;
            if (to || dir != p % 4 || g != eg || y != 3 || r != 0) begin
                n_fail++; $display("FAIL no_allred ph%0d: got dir %0d g %0d y %0d r %0d want %0d %0d 3 0",
                                   p, dir, g, y, r, p % 4, eg);
            end
            n_tests++;
            if (multi || !lok) begin
                n_fail++; $display("FAIL one_light ph%0d: got multi %0b light_ok %0b want 0 1", p, multi, lok);
            end
        end
    endtask

    task automatic test_reset_mid_yellow();
        int dir, lvl, rem0, g, gt, y, r, pvs, cnt;
        bit lok, multi, hb, to;
        sel_b = 8'h00; glo = 5'd2;
        do_reset();
        cnt = 0;
        tick = 1'b1;
        while (!(ifb.o_active_dir == 2'd2 && ifb.o_light[5:4] == 2'b10) && cnt < 2000) begin
            cyc(); cnt++;
        end
        tick = 1'b0;
        n_tests++;
        if (cnt >= 2000) begin
            n_fail++; $display("FAIL reach_yellow2: got timeout after %0d cycles want dir2 yellow", cnt);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (ifb.o_light !== 8'b0 || ifb.o_active_dir !== 2'd0 || ifb.o_remain !== 5'd0 || ifb.o_level !== 2'd0) begin
            n_fail++; $display("FAIL async_reset: got light %b dir %0d rem %0d lvl %0d want 0 0 0 0",
                               ifb.o_light, ifb.o_active_dir, ifb.o_remain, ifb.o_level);
        end
        cyc();
        reset = 1'b0;
        measure(1, 2, 0, 0, 1'b0, 1'b0, dir, lvl, rem0, g, gt, y, r, pvs, lok, multi, hb, to);
        n_tests++;
        if (to || dir != 0 || g != 2) begin
            n_fail++; $display("FAIL restart_dir: got dir %0d g %0d want 0 2", dir, g);
        end
    endtask

    task automatic test_random();
        int dir, lvl, rem0, g, gt, y, r, pvs, n, ed, eg, per;
        bit lok, multi, hb, to, scr, hy;
        logic [1:0] el;
        for (int which = 0; which < 2; which++) begin
            n = (which == 0) ? 2 : 4;
            sel_a = 4'($urandom); sel_b = 8'($urandom);
            glo = 5'($urandom); gmid = 5'($urandom); ghi = 5'($urandom);
            do_reset();
            ed = 0;
            for (int p = 0; p < 2 * n + 1; p++) begin
                el  = sel_of(which, ed);
                eg  = exp_green(el, glo, gmid, ghi);
                per = int'($urandom_range(1, 3));
                scr = 1'($urandom);
                hy  = 1'($urandom);
                measure(which, per, 0, 0, hy, scr, dir, lvl, rem0, g, gt, y, r, pvs, lok, multi, hb, to);
                n_tests++;
                if (to || dir != ed || lvl != int'(el)) begin
                    n_fail++; $display("FAIL rand_sel dut%0d ph%0d: got dir %0d lvl %0d want %0d %0d",
                                       which, p, dir, lvl, ed, el);
                end
                n_tests++;
                if (rem0 != eg || g != eg || y != 3 || r != ((which == 0) ? 1 : 0)) begin
                    n_fail++; $display("FAIL rand_dur dut%0d ph%0d: got rem0 %0d g %0d y %0d r %0d want %0d %0d 3 %0d",
                                       which, p, rem0, g, y, r, eg, eg, (which == 0) ? 1 : 0);
                end
                n_tests++;
                if (pvs != 1 || multi || !lok) begin
                    n_fail++; $display("FAIL rand_safety dut%0d ph%0d: got pvs %0d multi %0b light_ok %0b want 1 0 1",
                                       which, p, pvs, multi, lok);
                end
                ed = (ed + 1) % n;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_cycle();
        test_levels();
        test_hold();
        test_load_tick();
        test_no_allred();
        test_reset_mid_yellow();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
